// File: rtl/adc_scale_avg_if.sv
// Sample input and FIFO write port bundle for adc_scale_avg.
// The slave side is the averaging block; the master side is the sample source / FIFO owner.
interface adc_scale_avg_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16,
  parameter int CH_W   = 2
);
  logic [DATA_W-1:0] adc_data;
  logic [CH_W-1:0]   adc_ch;
  logic              valid_in;
  logic              ready_out;
  logic              fifo_full;
  logic              wr_en;
  logic [OUT_W-1:0]  result_data;
  logic [CH_W-1:0]   result_ch;
  logic              sat_flag;

  modport master (
    output adc_data, adc_ch, valid_in, fifo_full,
    input  ready_out, wr_en, result_data, result_ch, sat_flag
  );

  modport slave (
    input  adc_data, adc_ch, valid_in, fifo_full,
    output ready_out, wr_en, result_data, result_ch, sat_flag
  );
endinterface

// File: rtl/adc_scale_avg.sv
// Multi-channel ADC averager: per-channel accumulate 2^AVG_LOG2 samples, scale to mV with
// rounding and saturation, and write result plus channel tag into a downstream FIFO.
module adc_scale_avg #(
  parameter int DATA_W   = 16,
  parameter int OUT_W    = 16,
  parameter int NUM_CH   = 4,
  parameter int AVG_LOG2 = 2,
  parameter int SCALE    = 1000,
  parameter int SHIFT    = 16,
  parameter int ROUND    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  adc_scale_avg_if.slave      bus,
  output logic                ch_err,
  output logic [7:0]          drop_cnt
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PROD_W = ACC_W + 24;
  localparam int K      = SHIFT + AVG_LOG2;
  // With AVG_LOG2 = 0 the counter never leaves 0, so every sample closes its group.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [23:0]      SCALE_V  = 24'(SCALE);
  localparam logic [PROD_W:0]  RND_ADD  = (ROUND != 0) ? ((PROD_W + 1)'(1) << (K - 1)) : '0;

  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];

  logic              stall, ch_ok, accept, last;
  logic [CH_W-1:0]   ch_idx;
  logic [ACC_W-1:0]  sum_new;

  logic              s1_valid, s2_valid, s3_valid;
  logic [ACC_W-1:0]  s1_sum;
  logic [CH_W-1:0]   s1_ch, s2_ch;
  logic [PROD_W-1:0] s2_prod;
  logic [PROD_W:0]   rounded, shifted;
  logic [OUT_W-1:0]  res_next, res_q;
  logic              sat_next, sat_q;
  logic [CH_W-1:0]   rch_q;

  always_comb begin
    stall   = s3_valid & bus.fifo_full;
    ch_ok   = (int'(bus.adc_ch) < NUM_CH);
    ch_idx  = ch_ok ? bus.adc_ch : '0;
    accept  = bus.valid_in & ~stall & ~clr & ch_ok;
    last    = (cnt[ch_idx] == CNT_LAST);
    sum_new = acc[ch_idx] + ACC_W'(bus.adc_data);
  end

  assign bus.ready_out   = ~stall;
  assign bus.wr_en       = s3_valid & ~bus.fifo_full;
  assign bus.result_data = res_q;
  assign bus.result_ch   = rch_q;
  assign bus.sat_flag    = sat_q;

  // Accumulators follow clr even during a stall; only the result pipeline freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else if (clr) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else if (accept) begin
      if (last) begin
        acc[ch_idx] <= '0;
        cnt[ch_idx] <= '0;
      end else begin
        acc[ch_idx] <= sum_new;
        cnt[ch_idx] <= cnt[ch_idx] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rounded  = {1'b0, s2_prod} + RND_ADD;
    shifted  = rounded >> K;
    sat_next = |shifted[PROD_W:OUT_W];
    res_next = sat_next ? '1 : shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_ch    <= '0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_ch    <= '0;
      s3_valid <= 1'b0;
      res_q    <= '0;
      rch_q    <= '0;
      sat_q    <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept & last;
      if (accept & last) begin
        s1_sum <= sum_new;
        s1_ch  <= ch_idx;
      end
      s2_valid <= s1_valid;
      s2_prod  <= PROD_W'(s1_sum) * PROD_W'(SCALE_V);
      s2_ch    <= s1_ch;
      s3_valid <= s2_valid;
      res_q    <= res_next;
      rch_q    <= s2_ch;
      sat_q    <= sat_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_err   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ch_err <= bus.valid_in & ~stall & ~clr & ~ch_ok;
      if (bus.valid_in & stall & ~clr & (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_adc_scale_avg.sv
// Bench for adc_scale_avg: three parameterisations share one stimulus stream and are each
// checked every cycle against a group-level arithmetic model, plus literal spot checks.
module tb_adc_scale_avg;
  logic        clk, rst_n, clr, valid_in, fifo_full;
  logic [15:0] adc_data;
  logic [1:0]  adc_ch;
  logic        ch_err_a, ch_err_b, ch_err_c;
  logic [7:0]  drop_a, drop_b, drop_c;

  int n_cmp = 0;
  int n_bad = 0;

  adc_scale_avg_if #(.DATA_W(16), .OUT_W(16), .CH_W(2)) if_a ();
  adc_scale_avg_if #(.DATA_W(16), .OUT_W(16), .CH_W(2)) if_b ();
  adc_scale_avg_if #(.DATA_W(16), .OUT_W(16), .CH_W(2)) if_c ();

  assign if_a.adc_data = adc_data;  assign if_a.adc_ch = adc_ch;
  assign if_a.valid_in = valid_in;  assign if_a.fifo_full = fifo_full;
  assign if_b.adc_data = adc_data;  assign if_b.adc_ch = adc_ch;
  assign if_b.valid_in = valid_in;  assign if_b.fifo_full = fifo_full;
  assign if_c.adc_data = adc_data;  assign if_c.adc_ch = adc_ch;
  assign if_c.valid_in = valid_in;  assign if_c.fifo_full = fifo_full;

  adc_scale_avg #(.DATA_W(16), .OUT_W(16), .NUM_CH(3), .AVG_LOG2(2), .SCALE(1000),
                  .SHIFT(16), .ROUND(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_a), .ch_err(ch_err_a), .drop_cnt(drop_a));
  adc_scale_avg #(.DATA_W(16), .OUT_W(16), .NUM_CH(3), .AVG_LOG2(0), .SCALE(1000),
                  .SHIFT(16), .ROUND(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_b), .ch_err(ch_err_b), .drop_cnt(drop_b));
  adc_scale_avg #(.DATA_W(16), .OUT_W(16), .NUM_CH(3), .AVG_LOG2(0), .SCALE(70000),
                  .SHIFT(16), .ROUND(1)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_c), .ch_err(ch_err_c), .drop_cnt(drop_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    longint res;
    int     ch;
    bit     sat;
    longint stamp;
  } item_t;

  int     m_avg   [3] = '{2, 0, 0};
  longint m_scale [3] = '{1000, 1000, 70000};
  longint m_sum   [3][3];
  int     m_cnt   [3][3];
  int     m_drop  [3];
  bit     m_cherr [3];
  longint m_adv   [3];
  item_t  pq      [3][$];
  bit     m_st;

  function automatic item_t make_item(input int i, input longint sum, input int ch);
    item_t  it;
    longint k, one, r;
    k   = 16 + m_avg[i];
    one = 1;
    r   = (sum * m_scale[i] + (one << (k - 1))) >> k;
    it.sat   = (r > 65535);
    it.res   = it.sat ? 65535 : r;
    it.ch    = ch;
    it.stamp = m_adv[i];
    return it;
  endfunction

  // A finished group reaches the output register after two unstalled edges.
  function automatic bit at_out(input int i);
    return (pq[i].size() > 0) && ((m_adv[i] - pq[i][0].stamp) == 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        pq[i].delete();
        m_drop[i]  = 0;
        m_cherr[i] = 0;
        for (int c = 0; c < 3; c++) begin
          m_sum[i][c] = 0;
          m_cnt[i][c] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_st       = at_out(i) && fifo_full;
        m_cherr[i] = 0;
        if (!m_st) begin
          if (at_out(i)) void'(pq[i].pop_front());
          m_adv[i]++;
        end
        if (clr) begin
          for (int c = 0; c < 3; c++) begin
            m_sum[i][c] = 0;
            m_cnt[i][c] = 0;
          end
        end else if (valid_in) begin
          if (m_st) begin
            if (m_drop[i] < 255) m_drop[i]++;
          end else if (int'(adc_ch) >= 3) begin
            m_cherr[i] = 1;
          end else begin
            m_sum[i][adc_ch] += longint'(adc_data);
            m_cnt[i][adc_ch]++;
            if (m_cnt[i][adc_ch] == (1 << m_avg[i])) begin
              pq[i].push_back(make_item(i, m_sum[i][adc_ch], int'(adc_ch)));
              m_sum[i][adc_ch] = 0;
              m_cnt[i][adc_ch] = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input string nm, input logic rdy, input logic wr,
                          input logic [15:0] rd, input logic [1:0] rc, input logic sf,
                          input logic ce, input logic [7:0] dc);
    bit o;
    o = at_out(i);
    chk({nm, ".ready_out"}, rdy, !(o && fifo_full));
    chk({nm, ".wr_en"}, wr, o && !fifo_full);
    if (o && !fifo_full) begin
      chk({nm, ".result_data"}, rd, pq[i][0].res);
      chk({nm, ".result_ch"}, rc, pq[i][0].ch);
      chk({nm, ".sat_flag"}, sf, pq[i][0].sat);
    end
    chk({nm, ".ch_err"}, ce, m_cherr[i]);
    chk({nm, ".drop_cnt"}, dc, m_drop[i]);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, "A", if_a.ready_out, if_a.wr_en, if_a.result_data, if_a.result_ch,
             if_a.sat_flag, ch_err_a, drop_a);
    cmp_inst(1, "B", if_b.ready_out, if_b.wr_en, if_b.result_data, if_b.result_ch,
             if_b.sat_flag, ch_err_b, drop_b);
    cmp_inst(2, "C", if_c.ready_out, if_c.wr_en, if_c.result_data, if_c.result_ch,
             if_c.sat_flag, ch_err_c, drop_c);
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [1:0] ch, input logic [15:0] d,
                      input logic cl, input logic ff);
    @(posedge clk);
    #1;
    valid_in  = v;
    adc_ch    = ch;
    adc_data  = d;
    clr       = cl;
    fifo_full = ff;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic smp(input logic [1:0] ch, input logic [15:0] d);
    step(1'b1, ch, d, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; clr = 1'b0; valid_in = 1'b0; fifo_full = 1'b0;
    adc_data = '0; adc_ch = '0;
    #2 rst_n = 1'b0;
    idle();
    chk("rst_ready", if_a.ready_out, 1);
    chk("rst_wr", if_a.wr_en, 0);
    chk("rst_data", if_a.result_data, 0);
    chk("rst_drop", drop_a, 0);
    idle();
    #1 rst_n = 1'b1;
    idle();

    // Single-sample scaling, latency, saturation
    smp(2'd0, 16'hFFFF);
    smp(2'd0, 16'h8000);
    smp(2'd0, 16'h0000);
    chk("t1_lat_wr_early", if_b.wr_en, 0);
    idle();
    chk("t1_wr", if_b.wr_en, 1);
    chk("t1_ffff", if_b.result_data, 1000);
    chk("t1_ffff_sat", if_b.sat_flag, 0);
    chk("t3_sat_data", if_c.result_data, 16'hFFFF);
    chk("t3_sat_flag", if_c.sat_flag, 1);
    idle();
    chk("t1_8000", if_b.result_data, 500);
    chk("t3_8000", if_c.result_data, 35000);
    chk("t3_8000_sat", if_c.sat_flag, 0);
    idle();
    chk("t1_zero_wr", if_b.wr_en, 1);
    chk("t1_zero", if_b.result_data, 0);
    idle();
    chk("t1_done", if_b.wr_en, 0);
    step(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0);

    // Interleaved 4-sample averages on ch1/ch2
    smp(2'd1, 16'h4000); smp(2'd2, 16'h1000);
    smp(2'd1, 16'h4000); smp(2'd2, 16'h1000);
    smp(2'd1, 16'hC000); smp(2'd2, 16'h1000);
    smp(2'd1, 16'hC000);
    idle(); idle();
    chk("t2_early", if_a.wr_en, 0);
    idle();
    chk("t2_wr", if_a.wr_en, 1);
    chk("t2_data", if_a.result_data, 500);
    chk("t2_ch", if_a.result_ch, 1);
    idle(); chk("t2_once", if_a.wr_en, 0);
    idle(); chk("t2_ch2_pending", if_a.wr_en, 0);
    smp(2'd2, 16'h1000);
    idle(); idle(); idle();
    chk("t2_ch2_wr", if_a.wr_en, 1);
    chk("t2_ch2_data", if_a.result_data, 63);
    chk("t2_ch2_ch", if_a.result_ch, 2);

    // Invalid channel and clear-with-sample
    smp(2'd3, 16'hFFFF);
    chk("t5_cherr_pre", ch_err_a, 0);
    idle(); chk("t5_cherr", ch_err_a, 1);
    idle(); chk("t5_cherr_end", ch_err_a, 0);
    smp(2'd2, 16'h2000); smp(2'd2, 16'h2000);
    step(1'b1, 2'd2, 16'h2000, 1'b1, 1'b0);
    smp(2'd2, 16'h3000); smp(2'd2, 16'h3000); smp(2'd2, 16'h3000);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("t5_no_early", if_a.wr_en, 0);
    end
    smp(2'd2, 16'h3000);
    idle(); idle(); idle();
    chk("t5_wr", if_a.wr_en, 1);
    chk("t5_data", if_a.result_data, 188);
    chk("t5_drop", drop_a, 0);

    // Backpressure: hold a result in the output stage, drop three samples
    for (int k = 0; k < 4; k++) smp(2'd0, 16'h8000);
    idle();
    step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1);
    chk("t4_ready_empty", if_a.ready_out, 1);
    step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1);
    chk("t4_held_wr", if_a.wr_en, 0);
    chk("t4_held_ready", if_a.ready_out, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'd0, 16'h1234, 1'b0, 1'b1);
      chk("t4_stall_ready", if_a.ready_out, 0);
    end
    step(1'b0, 2'd0, 16'h0000, 1'b0, 1'b1);
    chk("t4_drop", drop_a, 3);
    chk("t4_stall_wr", if_a.wr_en, 0);
    smp(2'd0, 16'h8000);
    chk("t4_release_wr", if_a.wr_en, 1);
    chk("t4_release_data", if_a.result_data, 500);
    chk("t4_release_ready", if_a.ready_out, 1);
    smp(2'd0, 16'h8000);
    chk("t4_written_once", if_a.wr_en, 0);
    smp(2'd0, 16'h8000);

    // Reset mid-average
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("t6_wr", if_a.wr_en, 0);
    chk("t6_data", if_a.result_data, 0);
    chk("t6_sat", if_a.sat_flag, 0);
    chk("t6_drop", drop_a, 0);
    chk("t6_ready", if_a.ready_out, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) smp(2'd0, 16'h8000);
    idle(); idle(); idle();
    chk("t6_post_wr", if_a.wr_en, 1);
    chk("t6_post_data", if_a.result_data, 500);
    chk("t6_post_ch", if_a.result_ch, 0);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
